pipe_hazard_ctrl: RTL and testbench

//   Central pipeline control for the 5-stage core. Drives freeze/flush into the IF and ID/EX pipeline registers
//   and freeze into the EX/MEM and MEM/WB registers. Sources: load-use/RAW hazards on the ID-stage operands,

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush control for the 5-stage core: RAW/load-use hazards, EX branch flushes
// and multi-cycle SRAM stalls, plus saturating stall/bubble performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_FILE_DEPTH = 4,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_FILE_DEPTH-1:0] id_src1,
  input  logic [REG_FILE_DEPTH-1:0] id_src2,
  input  logic                      id_two_src,
  input  logic                      id_valid,
  input  logic                      ex_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] ex_dst,
  input  logic                      ex_mem_read,
  input  logic                      mem_wb_en,
  input  logic [REG_FILE_DEPTH-1:0] mem_dst,
  input  logic                      fwd_en,
  input  logic                      branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_freeze,
  output logic                      if_freeze,
  output logic                      if_flush,
  output logic                      id_freeze,
  output logic                      id_flush,
  output logic                      back_freeze,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      bubble_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

  mem_state_t        state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              timeout_next;
  logic              flush_pending_reg, flush_pending_next;

  logic mem_freeze;
  logic raw1, raw2, load_use, hazard, br_flush;

  // Hazard detection on the ID operands
  always_comb begin
    raw1     = (ex_wb_en && ex_dst == id_src1) || (mem_wb_en && mem_dst == id_src1);
    raw2     = id_two_src && ((ex_wb_en && ex_dst == id_src2) || (mem_wb_en && mem_dst == id_src2));
    load_use = ex_mem_read && ex_wb_en &&
               (ex_dst == id_src1 || (id_two_src && ex_dst == id_src2));
    hazard   = id_valid && (fwd_en ? load_use : (raw1 || raw2));
  end

  assign mem_freeze = mem_req && !mem_ready;
  assign br_flush   = branch_taken || flush_pending_reg;

  assign back_freeze = mem_freeze;
  assign id_freeze   = mem_freeze;
  assign pc_freeze   = mem_freeze || (hazard && !br_flush);
  assign if_freeze   = pc_freeze;
  assign if_flush    = br_flush && !mem_freeze;
  assign id_flush    = br_flush || hazard;

  // Memory wait FSM and pending-flush bookkeeping
  always_comb begin
    state_next         = state_reg;
    wait_cnt_next      = wait_cnt_reg;
    timeout_next       = mem_timeout;
    flush_pending_next = mem_freeze ? (flush_pending_reg || branch_taken) : 1'b0;
    case (state_reg)
      M_IDLE: begin
        if (mem_req && !mem_ready) begin
          state_next    = M_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      M_WAIT: begin
        if (wait_cnt_reg == WAIT_MAX) timeout_next = 1'b1;
        if (mem_ready) begin
          state_next    = M_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_MAX) begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      default: begin
        state_next    = M_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= M_IDLE;
      wait_cnt_reg      <= '0;
      mem_timeout       <= 1'b0;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      wait_cnt_reg      <= wait_cnt_next;
      mem_timeout       <= timeout_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (mem_freeze && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (hazard && !mem_freeze && !br_flush && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random stimulus,
// all compared against a behavioural model of the control rules.
module tb_pipe_hazard_ctrl;

  localparam int RD = 4;
  localparam int MT = 4;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RD-1:0] id_src1, id_src2, ex_dst, mem_dst;
  logic id_two_src, id_valid, ex_wb_en, ex_mem_read, mem_wb_en, fwd_en;
  logic branch_taken, mem_req, mem_ready;
  logic pc_freeze, if_freeze, if_flush, id_freeze, id_flush, back_freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_waiting, m_timeout, m_pending;
  int m_wait, m_stall, m_bubble;

  pipe_hazard_ctrl #(.REG_FILE_DEPTH(RD), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .ex_wb_en(ex_wb_en), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_freeze(if_freeze), .if_flush(if_flush),
    .id_freeze(id_freeze), .id_flush(id_flush), .back_freeze(back_freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_src1 = '0; id_src2 = '0; id_two_src = 0; id_valid = 0;
    ex_wb_en = 0; ex_dst = '0; ex_mem_read = 0; mem_wb_en = 0; mem_dst = '0;
    fwd_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_timeout = 0; m_pending = 0;
    m_wait = 0; m_stall = 0; m_bubble = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    bit [15:0] writers, needs;
    bit stall, hz, brf, e_pcf;
    writers = '0;
    if (ex_wb_en)  writers[ex_dst]  = 1'b1;
    if (mem_wb_en) writers[mem_dst] = 1'b1;
    needs = '0;
    needs[id_src1] = 1'b1;
    if (id_two_src) needs[id_src2] = 1'b1;
    stall = mem_req && !mem_ready;
    if (!id_valid)    hz = 0;
    else if (!fwd_en) hz = |(needs & writers);
    else              hz = ex_mem_read && ex_wb_en && needs[ex_dst];
    brf   = branch_taken || m_pending;
    e_pcf = stall || (hz && !brf);
    #1;
    check("pc_freeze",   pc_freeze,   e_pcf);
    check("if_freeze",   if_freeze,   e_pcf);
    check("if_flush",    if_flush,    brf && !stall);
    check("id_freeze",   id_freeze,   stall);
    check("id_flush",    id_flush,    brf || hz);
    check("back_freeze", back_freeze, stall);
    check("mem_timeout", mem_timeout, m_timeout);
    check("stall_cnt",   stall_cnt,   m_stall);
    check("bubble_cnt",  bubble_cnt,  m_bubble);
    @(posedge clk);
    if (stall) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    if (hz && !stall && !brf) m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
    m_pending = stall ? (m_pending || branch_taken) : 0;
    if (!m_waiting) begin
      if (stall) begin m_waiting = 1; m_wait = 1; end
    end else begin
      if (m_wait == MT) m_timeout = 1;
      if (mem_ready) begin m_waiting = 0; m_wait = 0; end
      else if (m_wait < MT) m_wait++;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("rst_pc_freeze", pc_freeze, 0);
    check("rst_if_flush", if_flush, 0);
    check("rst_id_flush", id_flush, 0);
    check("rst_back_freeze", back_freeze, 0);
    check("rst_mem_timeout", mem_timeout, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int s0, b0;

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state with idle inputs
    cycle();

    // RAW hazard without forwarding
    id_valid = 1; ex_wb_en = 1; ex_dst = 3; id_src1 = 3;
    b0 = bubble_cnt;
    cycle();
    check("t1_bubble_delta", bubble_cnt - b0, 1);

    // Load-use with forwarding, then plain ALU producer (no stall)
    idle_inputs();
    id_valid = 1; fwd_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dst = 5;
    id_two_src = 1; id_src2 = 5; id_src1 = 1;
    cycle();
    ex_mem_read = 0;
    cycle();

    // Three-cycle SRAM stall
    idle_inputs();
    s0 = stall_cnt;
    mem_req = 1;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    check("t3_stall_delta", stall_cnt - s0, 3);
    idle_inputs();
    cycle();

    // Branch resolved during a stall: flush is held then delivered
    mem_req = 1; branch_taken = 1;
    cycle();
    branch_taken = 0;
    repeat (2) cycle();
    mem_ready = 1;
    cycle();
    idle_inputs();
    cycle();

    // Branch and load-use together: branch wins, no bubble
    id_valid = 1; fwd_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dst = 2; id_src1 = 2;
    branch_taken = 1;
    b0 = bubble_cnt;
    cycle();
    check("t5_bubble_delta", bubble_cnt - b0, 0);

    // SRAM never answers: timeout becomes sticky; reset mid-wait clears everything
    idle_inputs();
    mem_req = 1;
    repeat (MT + 3) cycle();
    check("t6_timeout", mem_timeout, 1);
    do_reset();
    cycle();

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      id_src1      = RD'($urandom_range(0, 3));
      id_src2      = RD'($urandom_range(0, 3));
      ex_dst       = RD'($urandom_range(0, 3));
      mem_dst      = RD'($urandom_range(0, 3));
      id_two_src   = $urandom_range(0, 1);
      id_valid     = ($urandom_range(0, 7) != 0);
      ex_wb_en     = $urandom_range(0, 1);
      ex_mem_read  = $urandom_range(0, 1);
      mem_wb_en    = $urandom_range(0, 1);
      fwd_en       = $urandom_range(0, 1);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = $urandom_range(0, 1);
      mem_ready    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
